// File: rtl/i2c_slave16.sv
// I2C target for the 16-bit-frame link: 16 data bits + 1 ACK bit per unit, MSB first.
// Bus is oversampled with clk; scl is never driven, sda is open-drain.
module i2c_slave16 #(
   parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        scl,
   inout  logic        sda,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   input  logic [15:0] tx_data,
   output logic        tx_req,
   output logic        busy,
   output logic        nack_seen
);

   typedef enum logic [2:0] {
      IDLE, HDR, HDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   state_t      state;
   logic        scl_s1, scl_s2, scl_prev;
   logic        sda_s1, sda_s2, sda_prev;
   logic        scl_rise, scl_fall, start_det, stop_det;
   logic [15:0] shreg;
   logic [4:0]  bit_cnt;
   logic        slot_hi;
   logic        sda_low;
   logic        rw;

   // sda_low is cleared by the async reset, so the bus is released immediately
   assign sda = sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_s1   <= 1'b1;
         scl_s2   <= 1'b1;
         scl_prev <= 1'b1;
         sda_s1   <= 1'b1;
         sda_s2   <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_s1   <= scl;
         scl_s2   <= scl_s1;
         scl_prev <= scl_s2;
         sda_s1   <= sda;
         sda_s2   <= sda_s1;
         sda_prev <= sda_s2;
      end
   end

   always_comb begin
      scl_rise  = scl_s2 & ~scl_prev;
      scl_fall  = ~scl_s2 & scl_prev;
      // scl must be high on both samples, so an sda edge coinciding with an scl fall is data
      start_det = scl_s2 & scl_prev & sda_prev & ~sda_s2;
      stop_det  = scl_s2 & scl_prev & ~sda_prev & sda_s2;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         slot_hi   <= 1'b0;
         sda_low   <= 1'b0;
         rw        <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         busy      <= 1'b0;
         nack_seen <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         nack_seen <= 1'b0;
         if (start_det) begin
            state   <= HDR;
            bit_cnt <= '0;
            slot_hi <= 1'b0;
            sda_low <= 1'b0;
            busy    <= 1'b0;
         end else if (stop_det) begin
            state   <= IDLE;
            bit_cnt <= '0;
            slot_hi <= 1'b0;
            sda_low <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               HDR, WR_DATA: begin
                  if (scl_rise && bit_cnt < 5'd16) begin
                     shreg   <= {shreg[14:0], sda_s2};
                     bit_cnt <= bit_cnt + 5'd1;
                  end else if (scl_fall && bit_cnt == 5'd16) begin
                     slot_hi <= 1'b0;
                     if (state == WR_DATA) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                        sda_low  <= 1'b1;
                        state    <= WR_ACK;
                     end else if (shreg[15:9] == SLAVE_ADDR) begin
                        rw      <= shreg[8];
                        tx_req  <= shreg[8];
                        busy    <= 1'b1;
                        sda_low <= 1'b1;
                        state   <= HDR_ACK;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               HDR_ACK, WR_ACK: begin
                  if (scl_rise) begin
                     slot_hi <= 1'b1;
                  end else if (scl_fall && slot_hi) begin
                     slot_hi <= 1'b0;
                     bit_cnt <= '0;
                     if (state == WR_ACK || !rw) begin
                        sda_low <= 1'b0;
                        state   <= WR_DATA;
                     end else begin
                        shreg   <= tx_data;
                        sda_low <= ~tx_data[15];
                        state   <= RD_DATA;
                     end
                  end
               end
               RD_DATA: begin
                  if (scl_fall) begin
                     if (bit_cnt == 5'd15) begin
                        sda_low <= 1'b0;
                        bit_cnt <= 5'd16;
                        slot_hi <= 1'b0;
                        state   <= RD_ACK;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        shreg   <= {shreg[14:0], 1'b0};
                        sda_low <= ~shreg[14];
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise && !slot_hi) begin
                     if (!sda_s2) begin
                        tx_req  <= 1'b1;
                        slot_hi <= 1'b1;
                     end else begin
                        nack_seen <= 1'b1;
                        state     <= IGNORE;
                     end
                  end else if (scl_fall && slot_hi) begin
                     slot_hi <= 1'b0;
                     bit_cnt <= '0;
                     shreg   <= tx_data;
                     sda_low <= ~tx_data[15];
                     state   <= RD_DATA;
                  end
               end
               default: begin
                  sda_low <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave16.sv
// Directed bench for i2c_slave16: a bit-banged 16-bit-frame master on a pulled-up sda line.
module tb_i2c_slave16;

   localparam int Q = 80;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        scl_r = 1'b1;
   logic        m_sda_low = 1'b0;
   logic [15:0] tx_data = '0;
   logic [15:0] rx_data;
   logic        rx_valid, tx_req, busy, nack_seen;
   wire         sda_bus;

   pullup (sda_bus);
   assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

   int n_cmp = 0;
   int n_bad = 0;
   int rxv_cnt = 0, txr_cnt = 0, nack_cnt = 0, busy_cnt = 0, sdrv_cnt = 0;

   i2c_slave16 #(.SLAVE_ADDR(7'h2A)) dut (
      .clk(clk), .reset_n(reset_n), .scl(scl_r), .sda(sda_bus),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
      .tx_req(tx_req), .busy(busy), .nack_seen(nack_seen)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rx_valid)  rxv_cnt  <= rxv_cnt + 1;
      if (tx_req)    txr_cnt  <= txr_cnt + 1;
      if (nack_seen) nack_cnt <= nack_cnt + 1;
      if (busy)      busy_cnt <= busy_cnt + 1;
      if (!sda_bus && !m_sda_low) sdrv_cnt <= sdrv_cnt + 1;
   end

   task automatic write_bit(input logic b);
      m_sda_low = !b; #Q;
      scl_r = 1'b1;   #(2*Q);
      scl_r = 1'b0;   #Q;
   endtask

   task automatic read_bit(output logic b);
      m_sda_low = 1'b0; #Q;
      scl_r = 1'b1;     #Q;
      b = sda_bus;      #Q;
      scl_r = 1'b0;     #Q;
   endtask

   task automatic send_word(input logic [15:0] w, output logic ack);
      for (int i = 15; i >= 0; i--) write_bit(w[i]);
      read_bit(ack);
   endtask

   task automatic recv_bits(output logic [15:0] w);
      for (int i = 15; i >= 0; i--) read_bit(w[i]);
   endtask

   task automatic start_c;
      m_sda_low = 1'b0; #Q;
      scl_r = 1'b1;     #Q;
      m_sda_low = 1'b1; #Q;
      scl_r = 1'b0;     #Q;
   endtask

   task automatic stop_c;
      m_sda_low = 1'b1; #Q;
      scl_r = 1'b1;     #Q;
      m_sda_low = 1'b0; #Q;
   endtask

   task automatic test_reset;
      #20;
      n_cmp++; if (rx_data !== 16'h0000) begin n_bad++; $display("FAIL reset_rx_data got %h want 0000", rx_data); end
      n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
      n_cmp++; if (tx_req !== 1'b0) begin n_bad++; $display("FAIL reset_tx_req got %b want 0", tx_req); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (nack_seen !== 1'b0) begin n_bad++; $display("FAIL reset_nack got %b want 0", nack_seen); end
      n_cmp++; if (sda_bus !== 1'b1) begin n_bad++; $display("FAIL reset_sda got %b want 1", sda_bus); end
      reset_n = 1'b1;
      #100;
   endtask

   task automatic test_write;
      logic ack;
      int rv0;
      rv0 = rxv_cnt;
      start_c;
      send_word(16'h5400, ack);
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL wr_hdr_ack got %b want 0", ack); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy_hdr got %b want 1", busy); end
      send_word(16'hBEEF, ack);
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL wr_data_ack got %b want 0", ack); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy_data got %b want 1", busy); end
      n_cmp++; if (rx_data !== 16'hBEEF) begin n_bad++; $display("FAIL wr_rx_data got %h want beef", rx_data); end
      stop_c;
      n_cmp++; if (rxv_cnt - rv0 !== 1) begin n_bad++; $display("FAIL wr_rx_valid_cnt got %0d want 1", rxv_cnt - rv0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_stop got %b want 0", busy); end
   endtask

   task automatic test_read;
      logic ack;
      logic [15:0] w;
      int tr0, nk0, rv0;
      tr0 = txr_cnt; nk0 = nack_cnt; rv0 = rxv_cnt;
      tx_data = 16'h1234;
      start_c;
      send_word(16'h5500, ack);
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rd_hdr_ack got %b want 0", ack); end
      recv_bits(w);
      n_cmp++; if (w !== 16'h1234) begin n_bad++; $display("FAIL rd_word0 got %h want 1234", w); end
      tx_data = 16'hA5A5;
      write_bit(1'b0);
      recv_bits(w);
      n_cmp++; if (w !== 16'hA5A5) begin n_bad++; $display("FAIL rd_word1 got %h want a5a5", w); end
      write_bit(1'b1);
      stop_c;
      n_cmp++; if (txr_cnt - tr0 !== 2) begin n_bad++; $display("FAIL rd_tx_req_cnt got %0d want 2", txr_cnt - tr0); end
      n_cmp++; if (nack_cnt - nk0 !== 1) begin n_bad++; $display("FAIL rd_nack_cnt got %0d want 1", nack_cnt - nk0); end
      n_cmp++; if (rxv_cnt - rv0 !== 0) begin n_bad++; $display("FAIL rd_rx_valid_cnt got %0d want 0", rxv_cnt - rv0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_stop got %b want 0", busy); end
   endtask

   task automatic test_addr_mismatch;
      logic ack;
      int b0, d0, rv0, tr0, nk0;
      b0 = busy_cnt; d0 = sdrv_cnt; rv0 = rxv_cnt; tr0 = txr_cnt; nk0 = nack_cnt;
      start_c;
      send_word(16'h2200, ack);
      n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL mis_ack got %b want 1", ack); end
      send_word(16'h00FF, ack);
      stop_c;
      n_cmp++; if (busy_cnt - b0 !== 0) begin n_bad++; $display("FAIL mis_busy_cycles got %0d want 0", busy_cnt - b0); end
      n_cmp++; if (sdrv_cnt - d0 !== 0) begin n_bad++; $display("FAIL mis_sda_driven got %0d want 0", sdrv_cnt - d0); end
      n_cmp++; if ((rxv_cnt - rv0) + (txr_cnt - tr0) + (nack_cnt - nk0) !== 0) begin
         n_bad++; $display("FAIL mis_pulses got %0d want 0", (rxv_cnt - rv0) + (txr_cnt - tr0) + (nack_cnt - nk0));
      end
   endtask

   task automatic test_rep_start;
      logic ack;
      logic [15:0] w;
      int rv0;
      rv0 = rxv_cnt;
      tx_data = 16'hC3C3;
      start_c;
      send_word(16'h5400, ack);
      send_word(16'h0001, ack);
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rs_data_ack got %b want 0", ack); end
      start_c;
      send_word(16'h5500, ack);
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rs_hdr_ack got %b want 0", ack); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rs_busy got %b want 1", busy); end
      recv_bits(w);
      n_cmp++; if (w !== 16'hC3C3) begin n_bad++; $display("FAIL rs_rd_word got %h want c3c3", w); end
      write_bit(1'b1);
      stop_c;
      n_cmp++; if (rxv_cnt - rv0 !== 1) begin n_bad++; $display("FAIL rs_rx_valid_cnt got %0d want 1", rxv_cnt - rv0); end
      n_cmp++; if (rx_data !== 16'h0001) begin n_bad++; $display("FAIL rs_rx_data got %h want 0001", rx_data); end
   endtask

   task automatic test_stop_mid;
      logic ack;
      int rv0;
      rv0 = rxv_cnt;
      start_c;
      send_word(16'h5400, ack);
      for (int i = 0; i < 7; i++) write_bit(1'b1);
      stop_c;
      n_cmp++; if (rxv_cnt - rv0 !== 0) begin n_bad++; $display("FAIL sm_rx_valid_cnt got %0d want 0", rxv_cnt - rv0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sm_busy got %b want 0", busy); end
      n_cmp++; if (sda_bus !== 1'b1) begin n_bad++; $display("FAIL sm_sda got %b want 1", sda_bus); end
      n_cmp++; if (rx_data !== 16'h0001) begin n_bad++; $display("FAIL sm_rx_data got %h want 0001", rx_data); end
   endtask

   task automatic test_reset_mid;
      logic ack;
      tx_data = 16'h0F0F;
      start_c;
      send_word(16'h5500, ack);
      n_cmp++; if (sda_bus !== 1'b0) begin n_bad++; $display("FAIL rm_sda_driven got %b want 0", sda_bus); end
      #3 reset_n = 1'b0;
      #1;
      n_cmp++; if (sda_bus !== 1'b1) begin n_bad++; $display("FAIL rm_sda_released got %b want 1", sda_bus); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy got %b want 0", busy); end
      n_cmp++; if (rx_data !== 16'h0000) begin n_bad++; $display("FAIL rm_rx_data got %h want 0000", rx_data); end
      n_cmp++; if ({rx_valid, tx_req, nack_seen} !== 3'b000) begin
         n_bad++; $display("FAIL rm_pulses got %b want 000", {rx_valid, tx_req, nack_seen});
      end
      #26 reset_n = 1'b1;
      #20 scl_r = 1'b1;
      #Q;
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_addr_mismatch;
      test_rep_start;
      test_stop_mid;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
